mem_line_seq: RTL and testbench

Cache-line transfer sequencer between the 2-way set-associative cache and main memory. It accepts one line-fill or line-writeback request, breaks it into four single-word memory accesses, and handshakes each one on `ready_mem`. Reads are returned critical-word-first, and every memory access is guarded by a timeout. The block sits in the stage-1 top between the cache's memory port and the main memory; the top keeps ownership of the bidirectional bus resolution.

---
 rtl/mem_ctrl_pkg.sv | 20 ++
 rtl/mem_wdog.sv | 27 ++
 rtl/mem_line_seq.sv | 167 ++++++++++++++++
 tb/tb_mem_line_seq.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the cache-line memory sequencer.
package mem_ctrl_pkg;

    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned OFFS_W     = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_BEAT = 2'd1,
        WR_BEAT = 2'd2,
        FIN     = 2'd3
    } seq_state_t;

    // Word index within a line for a given beat; wraps modulo LINE_WORDS.
    function automatic logic [OFFS_W-1:0] word_idx(input logic [OFFS_W-1:0] start_off,
                                                   input logic [OFFS_W-1:0] beat);
        return start_off + beat;
    endfunction

endpackage

// File: rtl/mem_wdog.sv
// Per-beat watchdog: counts cycles without ready and flags the cycle the limit is hit.
module mem_wdog #(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic clock,
    input  logic reset_n,
    input  logic start,
    input  logic ready,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clock) begin
        if (!reset_n || start) begin
            wait_cnt <= '0;
        end else if (!ready && (wait_cnt != CNT_W'(TIMEOUT_CYC))) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // A ready in the final cycle wins over the timeout.
    assign expired = !ready && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_line_seq.sv
// Cache-line transfer sequencer: splits a line fill/writeback into four
// handshaked memory beats, returns fills critical-word-first, with a per-beat timeout.
module mem_line_seq
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned AWIDTH      = 9,
    parameter int unsigned DWIDTH      = 8,
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       req_valid,
    input  logic                       req_write,
    input  logic [AWIDTH-1:0]          req_addr,
    input  logic [LINE_WORDS*DWIDTH-1:0] req_wline,
    output logic                       req_ready,
    output logic [LINE_WORDS*DWIDTH-1:0] rline,
    output logic                       crit_valid,
    output logic [DWIDTH-1:0]          crit_data,
    output logic                       done,
    output logic                       err,
    output logic                       rd_mem,
    output logic                       wr_mem,
    output logic [AWIDTH-1:0]          addr_mem,
    output logic [DWIDTH-1:0]          mem_wdata,
    input  logic [DWIDTH-1:0]          mem_rdata,
    input  logic                       ready_mem
);

    localparam int unsigned LINE_W = AWIDTH - OFFS_W;

    seq_state_t state, state_nxt;

    logic [LINE_W-1:0]                     line_q;
    logic [OFFS_W-1:0]                     start_off_q;
    logic [OFFS_W-1:0]                     beat_cnt;
    logic [LINE_WORDS-1:0][DWIDTH-1:0]     wline_q;
    logic [LINE_WORDS-1:0][DWIDTH-1:0]     rline_q;

    logic                in_beat;
    logic                last_beat;
    logic                accept;
    logic                expired;
    logic [OFFS_W-1:0]   cur_offs;
    logic [OFFS_W-1:0]   nxt_offs;

    logic                rd_nxt;
    logic                wr_nxt;
    logic                done_nxt;
    logic                err_nxt;
    logic                crit_nxt;
    logic [AWIDTH-1:0]   addr_nxt;
    logic [DWIDTH-1:0]   wdata_nxt;

    assign in_beat   = (state == RD_BEAT) || (state == WR_BEAT);
    assign last_beat = (beat_cnt == OFFS_W'(LINE_WORDS - 1));
    assign accept    = (state == IDLE) && req_valid;
    assign cur_offs  = word_idx(start_off_q, beat_cnt);
    assign nxt_offs  = word_idx(start_off_q, beat_cnt + OFFS_W'(1));
    assign req_ready = (state == IDLE);
    assign rline     = rline_q;

    // Watchdog restarts whenever a new beat begins or no beat is in flight.
    mem_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (!in_beat || ready_mem),
        .ready   (ready_mem),
        .expired (expired)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = req_write ? WR_BEAT : RD_BEAT;
                end
            end
            RD_BEAT, WR_BEAT: begin
                if (ready_mem) begin
                    if (last_beat) begin
                        state_nxt = FIN;
                    end
                end else if (expired) begin
                    state_nxt = FIN;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; address/data hold until a beat completes.
    always_comb begin
        rd_nxt    = (state_nxt == RD_BEAT);
        wr_nxt    = (state_nxt == WR_BEAT);
        done_nxt  = (state_nxt == FIN);
        err_nxt   = in_beat && expired;
        crit_nxt  = (state == RD_BEAT) && ready_mem && (beat_cnt == '0);
        addr_nxt  = addr_mem;
        wdata_nxt = mem_wdata;
        if (accept) begin
            addr_nxt = {req_addr[AWIDTH-1:OFFS_W],
                        req_write ? OFFS_W'(0) : req_addr[OFFS_W-1:0]};
            if (req_write) begin
                wdata_nxt = req_wline[DWIDTH-1:0];
            end
        end else if (in_beat && ready_mem && !last_beat) begin
            addr_nxt = {line_q, nxt_offs};
            if (state == WR_BEAT) begin
                wdata_nxt = wline_q[nxt_offs];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_mem      <= 1'b0;
            wr_mem      <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            crit_valid  <= 1'b0;
            crit_data   <= '0;
            addr_mem    <= '0;
            mem_wdata   <= '0;
            rline_q     <= '0;
            line_q      <= '0;
            start_off_q <= '0;
            beat_cnt    <= '0;
            wline_q     <= '0;
        end else begin
            rd_mem     <= rd_nxt;
            wr_mem     <= wr_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
            crit_valid <= crit_nxt;
            addr_mem   <= addr_nxt;
            mem_wdata  <= wdata_nxt;
            if (accept) begin
                line_q      <= req_addr[AWIDTH-1:OFFS_W];
                start_off_q <= req_write ? OFFS_W'(0) : req_addr[OFFS_W-1:0];
                wline_q     <= req_wline;
                beat_cnt    <= '0;
            end else if (in_beat && ready_mem) begin
                beat_cnt <= beat_cnt + OFFS_W'(1);
            end
            if ((state == RD_BEAT) && ready_mem) begin
                rline_q[cur_offs] <= mem_rdata;
                if (beat_cnt == '0) begin
                    crit_data <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_line_seq.sv
// Self-checking bench for mem_line_seq: table-driven transfers with a beat scoreboard.
module tb_mem_line_seq;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 15;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wline;
    logic          req_ready;
    logic [31:0]   rline;
    logic          crit_valid;
    logic [DW-1:0] crit_data;
    logic          done;
    logic          err;
    logic          rd_mem;
    logic          wr_mem;
    logic [AW-1:0] addr_mem;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          ready_mem;

    always #5 clock = ~clock;

    mem_line_seq #(
        .AWIDTH      (AW),
        .DWIDTH      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wline  (req_wline),
        .req_ready  (req_ready),
        .rline      (rline),
        .crit_valid (crit_valid),
        .crit_data  (crit_data),
        .done       (done),
        .err        (err),
        .rd_mem     (rd_mem),
        .wr_mem     (wr_mem),
        .addr_mem   (addr_mem),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .ready_mem  (ready_mem)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [31:0]   wline;
        int            mode;
        int            exp_k;
        logic          exp_err;
    } vec_t;

    beat_t       sbq[$];
    vec_t        vecs[8];
    logic [31:0] exp_rline = '0;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_model(input logic [AW-1:0] a);
        return a[7:0] ^ 8'hA5;
    endfunction

    // Memory response pattern per cycle k after accept.
    function automatic logic ready_for(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 3) == 0;
            2:       return 1'b0;
            default: return k >= int'(TO);
        endcase
    endfunction

    task automatic push_beats(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wline);
        beat_t       b;
        logic [1:0]  off;
        logic [31:0] sh;
        for (int i = 0; i < 4; i++) begin
            off    = wr ? 2'(i) : addr[1:0] + 2'(i);
            b.wr   = wr;
            b.addr = {addr[AW-1:2], off};
            sh     = wline >> (8 * i);
            b.data = wr ? sh[7:0] : mem_model(b.addr);
            sbq.push_back(b);
        end
    endtask

    task automatic start_req(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wline);
        int n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("req_ready_before_accept", 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wline = wline;
        ready_mem = 1'b0;
        push_beats(wr, addr, wline);
    endtask

    task automatic run_beats(input int mode, input logic hold, input int exp_k,
                             input logic exp_err, input logic wr);
        int            done_k  = 0;
        int            strobes = 0;
        int            first_k = 0;
        int            crits   = 0;
        logic [DW-1:0] exp_crit = '0;
        beat_t         b;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (!hold) req_valid = 1'b0;
            if (crit_valid) begin
                crits++;
                chk("crit_timing", 64'(k), 64'(first_k + 1));
                chk("crit_data", 64'(crit_data), 64'(exp_crit));
            end
            if (done) begin
                done_k = k;
                chk("done_cycle", 64'(k), 64'(exp_k));
                chk("err", 64'(err), 64'(exp_err));
                chk("rline", 64'(rline), 64'(exp_rline));
                chk("strobes_in_fin", 64'({rd_mem, wr_mem}), 64'(0));
                chk("req_ready_in_fin", 64'(req_ready), 64'(0));
            end else if (rd_mem || wr_mem) begin
                strobes++;
                if (sbq.size() == 0) begin
                    chk("scoreboard_depth", 64'(sbq.size()), 64'(1));
                end else begin
                    b = sbq[0];
                    chk("strobe_dir", 64'({rd_mem, wr_mem}), b.wr ? 64'(1) : 64'(2));
                    chk("addr_mem", 64'(addr_mem), 64'(b.addr));
                    if (b.wr) chk("mem_wdata", 64'(mem_wdata), 64'(b.data));
                end
            end
            ready_mem = ready_for(mode, k);
            mem_rdata = mem_model(addr_mem);
            if ((rd_mem || wr_mem) && !done && ready_mem && sbq.size() != 0) begin
                b = sbq.pop_front();
                if (!b.wr) begin
                    exp_rline[32'(b.addr[1:0]) * 8 +: 8] = b.data;
                    if (first_k == 0) begin
                        first_k  = k;
                        exp_crit = b.data;
                    end
                end
            end
            if (done_k != 0) break;
        end
        chk("done_seen", 64'(done_k != 0), 64'(1));
        chk("strobe_cycles", 64'(strobes), 64'(exp_k - 1));
        chk("crit_count", 64'(crits), 64'((!wr && first_k != 0) ? 1 : 0));
        @(negedge clock);
        ready_mem = 1'b0;
        chk("req_ready_after_done", 64'(req_ready), 64'(1));
        chk("done_pulse_width", 64'(done), 64'(0));
        chk("strobes_idle", 64'({rd_mem, wr_mem}), 64'(0));
        sbq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{wr: 1'b0, addr: 9'h012, wline: 32'h0,        mode: 0, exp_k: 5,      exp_err: 1'b0};
        vecs[1] = '{wr: 1'b1, addr: 9'h0F3, wline: 32'h44332211, mode: 0, exp_k: 5,      exp_err: 1'b0};
        vecs[2] = '{wr: 1'b0, addr: 9'h012, wline: 32'h0,        mode: 1, exp_k: 13,     exp_err: 1'b0};
        vecs[3] = '{wr: 1'b0, addr: 9'h1FD, wline: 32'h0,        mode: 0, exp_k: 5,      exp_err: 1'b0};
        vecs[4] = '{wr: 1'b1, addr: 9'h100, wline: 32'hA1B2C3D4, mode: 1, exp_k: 13,     exp_err: 1'b0};
        vecs[5] = '{wr: 1'b0, addr: 9'h0A1, wline: 32'h0,        mode: 2, exp_k: TO + 1, exp_err: 1'b1};
        vecs[6] = '{wr: 1'b1, addr: 9'h055, wline: 32'h99887766, mode: 2, exp_k: TO + 1, exp_err: 1'b1};
        vecs[7] = '{wr: 1'b0, addr: 9'h003, wline: 32'h0,        mode: 3, exp_k: TO + 4, exp_err: 1'b0};

        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wline = '0;
        mem_rdata = '0;
        ready_mem = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        chk("rst_flags", 64'({rd_mem, wr_mem, done, err, crit_valid}), 64'(0));
        chk("rst_addr_mem", 64'(addr_mem), 64'(0));
        chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_rline", 64'(rline), 64'(0));
        chk("rst_crit_data", 64'(crit_data), 64'(0));
        reset_n = 1'b1;
        @(negedge clock);

        foreach (vecs[i]) begin
            start_req(vecs[i].wr, vecs[i].addr, vecs[i].wline);
            run_beats(vecs[i].mode, 1'b0, vecs[i].exp_k, vecs[i].exp_err, vecs[i].wr);
        end

        // Stray ready while idle must not start anything.
        for (int i = 0; i < 3; i++) begin
            ready_mem = 1'b1;
            @(negedge clock);
            chk("stray_ready_idle", 64'(req_ready), 64'(1));
            chk("stray_ready_outputs", 64'({rd_mem, wr_mem, done, crit_valid}), 64'(0));
        end
        ready_mem = 1'b0;

        // Request held high: second copy accepted only after done.
        start_req(1'b0, 9'h0C6, 32'h0);
        run_beats(0, 1'b1, 5, 1'b0, 1'b0);
        push_beats(1'b0, 9'h0C6, 32'h0);
        run_beats(0, 1'b0, 5, 1'b0, 1'b0);

        // Reset during beat 2 of a writeback.
        start_req(1'b1, 9'h0F3, 32'hDDCCBBAA);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            req_valid = 1'b0;
            ready_mem = 1'b1;
            if (k == 3) begin
                chk("mid_reset_beat2_addr", 64'(addr_mem), 64'(9'h0F2));
                chk("mid_reset_beat2_wdata", 64'(mem_wdata), 64'(8'hCC));
                reset_n = 1'b0;
            end
        end
        @(negedge clock);
        reset_n   = 1'b1;
        ready_mem = 1'b0;
        sbq.delete();
        exp_rline = '0;
        chk("mid_reset_strobes", 64'({rd_mem, wr_mem}), 64'(0));
        chk("mid_reset_no_done", 64'(done), 64'(0));
        chk("mid_reset_req_ready", 64'(req_ready), 64'(1));
        chk("mid_reset_rline", 64'(rline), 64'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("post_reset_no_done", 64'({done, rd_mem, wr_mem}), 64'(0));
        end
        start_req(vecs[0].wr, vecs[0].addr, vecs[0].wline);
        run_beats(vecs[0].mode, 1'b0, vecs[0].exp_k, vecs[0].exp_err, vecs[0].wr);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
